// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the fetch PC, buffers ROM words in a small FIFO,
// and hands them to decode over valid/ready, with redirect flush and misaligned-target fault.
module fetch_controller #(
    parameter int unsigned                ADDRESS_WIDTH = 32,
    parameter int unsigned                DATA_WIDTH    = 32,
    parameter int unsigned                DEPTH         = 4,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [ADDRESS_WIDTH-1:0]     mem_addr,
    input  logic [DATA_WIDTH-1:0]        mem_instr,
    input  logic                         redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0]     redirect_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_instr,
    output logic [ADDRESS_WIDTH-1:0]     out_pc,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         fault,
    output logic [ADDRESS_WIDTH-1:0]     fault_pc
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]         occ_q, occ_d;
    logic                     fault_q, fault_d;
    logic [ADDRESS_WIDTH-1:0] fault_pc_q, fault_pc_d;

    logic [ADDRESS_WIDTH-1:0] buf_pc_q    [DEPTH];
    logic [DATA_WIDTH-1:0]    buf_instr_q [DEPTH];

    logic push;
    logic pop;

    assign mem_addr  = fetch_pc_q;
    assign out_valid = (occ_q != '0) && (state_q == RUN);
    assign out_instr = buf_instr_q[rd_ptr_q];
    assign out_pc    = buf_pc_q[rd_ptr_q];
    assign occupancy = occ_q;
    assign fault     = fault_q;
    assign fault_pc  = fault_pc_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        occ_d      = occ_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        pop        = out_valid & out_ready;
        push       = 1'b0;

        // Redirect wins over push/pop; any pop accepted this cycle is simply dropped by the flush.
        if (state_q != FAULT && redirect_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            occ_d    = '0;
            if (redirect_pc[1:0] == 2'b00) begin
                fetch_pc_d = redirect_pc;
                state_d    = RUN;
            end else begin
                state_d    = FAULT;
                fault_d    = 1'b1;
                fault_pc_d = redirect_pc;
            end
        end else begin
            case (state_q)
                IDLE: state_d = RUN;
                RUN: begin
                    push = (occ_q < FULL) | pop;
                    if (push) begin
                        fetch_pc_d = fetch_pc_q + ADDRESS_WIDTH'(4);
                        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                    end
                    if (pop) begin
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    end
                    if (push && !pop) begin
                        occ_d = occ_q + OCC_W'(1);
                    end else if (pop && !push) begin
                        occ_d = occ_q - OCC_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            occ_q      <= '0;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            occ_q      <= occ_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
            if (push) begin
                buf_pc_q[wr_ptr_q]    <= fetch_pc_q;
                buf_instr_q[wr_ptr_q] <= mem_instr;
            end
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: ROM word at address A is A>>2, so each
// fetched word identifies its own PC.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr;
    logic [31:0] mem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  occupancy;
    logic        fault;
    logic [31:0] fault_pc;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    assign mem_instr = {2'b00, mem_addr[31:2]};

    fetch_controller #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH   (32),
        .DEPTH        (4),
        .RESET_PC     (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_addr      (mem_addr),
        .mem_instr     (mem_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .occupancy     (occupancy),
        .fault         (fault),
        .fault_pc      (fault_pc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst            = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset state
        tick();
        tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_fault_pc", 64'(fault_pc), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'h0);

        // Startup: IDLE, then first push, then valid
        rst = 1'b0;
        tick();
        chk("idle_valid", 64'(out_valid), 64'd0);
        chk("idle_addr", 64'(mem_addr), 64'h0);
        tick();
        chk("start_valid", 64'(out_valid), 64'd1);
        chk("start_pc", 64'(out_pc), 64'h0);
        chk("start_instr", 64'(out_instr), 64'h0);
        chk("start_occ", 64'(occupancy), 64'd1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("stream_valid", 64'(out_valid), 64'd1);
            chk("stream_pc", 64'(out_pc), 64'(4 * i));
            chk("stream_instr", 64'(out_instr), 64'(i));
            chk("stream_occ", 64'(occupancy), 64'd1);
        end

        // Backpressure from reset
        rst       = 1'b1;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("bp_occ", 64'(occupancy), 64'(k));
            chk("bp_head_pc", 64'(out_pc), 64'h0);
        end
        tick();
        chk("bp_hold_occ", 64'(occupancy), 64'd4);
        chk("bp_hold_addr", 64'(mem_addr), 64'h10);
        chk("bp_hold_pc", 64'(out_pc), 64'h0);
        chk("bp_hold_valid", 64'(out_valid), 64'd1);

        // Release: full with simultaneous pop and push, no bubble
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("full_valid", 64'(out_valid), 64'd1);
            chk("full_pc", 64'(out_pc), 64'(4 * i));
            chk("full_occ", 64'(occupancy), 64'd4);
        end
        chk("full_addr", 64'(mem_addr), 64'h20);

        // Redirect flush from occupancy 3
        rst       = 1'b1;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("pre_rd_occ", 64'(occupancy), 64'd3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        out_ready      = 1'b1;
        tick();
        redirect_valid = 1'b0;
        chk("rd_n1_occ", 64'(occupancy), 64'd0);
        chk("rd_n1_valid", 64'(out_valid), 64'd0);
        chk("rd_n1_addr", 64'(mem_addr), 64'h200);
        tick();
        chk("rd_n2_valid", 64'(out_valid), 64'd1);
        chk("rd_n2_pc", 64'(out_pc), 64'h200);
        chk("rd_n2_instr", 64'(out_instr), 64'h80);
        tick();
        chk("rd_n3_pc", 64'(out_pc), 64'h204);
        tick();
        chk("rd_n4_pc", 64'(out_pc), 64'h208);

        // Address wrap
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        chk("wrap_flush_valid", 64'(out_valid), 64'd0);
        tick();
        chk("wrap_pc0", 64'(out_pc), 64'hFFFF_FFF8);
        chk("wrap_instr0", 64'(out_instr), 64'h3FFF_FFFE);
        tick();
        chk("wrap_pc1", 64'(out_pc), 64'hFFFF_FFFC);
        tick();
        chk("wrap_pc2", 64'(out_pc), 64'h0);
        tick();
        chk("wrap_pc3", 64'(out_pc), 64'h4);
        chk("wrap_addr", 64'(mem_addr), 64'h8);

        // Misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        tick();
        chk("mis_fault", 64'(fault), 64'd1);
        chk("mis_fault_pc", 64'(fault_pc), 64'h102);
        chk("mis_valid", 64'(out_valid), 64'd0);
        chk("mis_occ", 64'(occupancy), 64'd0);
        chk("mis_addr", 64'(mem_addr), 64'h8);
        redirect_pc = 32'h300;
        tick();
        redirect_valid = 1'b0;
        chk("mis_ign_fault_pc", 64'(fault_pc), 64'h102);
        chk("mis_ign_addr", 64'(mem_addr), 64'h8);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mis_stuck_valid", 64'(out_valid), 64'd0);
            chk("mis_stuck_fault", 64'(fault), 64'd1);
        end

        // Reset clears fault and restarts at RESET_PC
        rst = 1'b1;
        tick();
        chk("clr_fault", 64'(fault), 64'd0);
        chk("clr_fault_pc", 64'(fault_pc), 64'h0);
        chk("clr_addr", 64'(mem_addr), 64'h0);
        rst = 1'b0;
        tick();
        chk("restart_idle_valid", 64'(out_valid), 64'd0);
        tick();
        chk("restart_valid", 64'(out_valid), 64'd1);
        chk("restart_pc", 64'(out_pc), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
